// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage pipelined fp32 multiplier with valid/ready flow control and tag passthrough.
// Define FMUL_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module fmul_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      p,
    output logic [TAG_W-1:0] out_tag
);

`ifdef FMUL_ROUND_NEAREST_EN
    localparam int PLSB = 0;
`else
    localparam int PLSB = 23;
`endif

    logic               v1_r, v2_r, v3_r;
    logic               adv1_s, adv2_s, adv3_s;

    logic [7:0]         ea_s, eb_s;
    logic               any_nan_s, any_inf_s, any_zero_s;
    logic signed [9:0]  esum_s;
    logic [47:0]        prod_s;

    logic               s1_sign_r, s1_nan_r, s1_inf_r, s1_zero_r;
    logic signed [9:0]  s1_esum_r;
    logic [47:PLSB]     s1_prod_r;
    logic [TAG_W-1:0]   s1_tag_r;

    logic [22:0]        mant_s;
    logic signed [9:0]  esum_n_s;

    logic               s2_sign_r, s2_nan_r, s2_inf_r, s2_zero_r;
    logic signed [9:0]  s2_esum_r;
    logic [22:0]        s2_mant_r;
    logic [TAG_W-1:0]   s2_tag_r;

    logic [22:0]        mant_f_s;
    logic signed [9:0]  esum_f_s;
    logic [31:0]        pack_s;

`ifdef FMUL_ROUND_NEAREST_EN
    logic               guard_s, sticky_s;
    logic               s2_guard_r, s2_sticky_r;
`else
    logic               prod_unused_s;
    assign prod_unused_s = ^prod_s[22:0];
`endif

    // Bubble-collapsing advance chain; in_ready is combinational from out_ready.
    always_comb begin
        adv3_s = !v3_r || out_ready;
        adv2_s = !v2_r || adv3_s;
        adv1_s = !v1_r || adv2_s;
    end

    assign in_ready  = adv1_s;
    assign out_valid = v3_r;

    // Unpack: operand classes (denormals count as zero), biased exponent sum, mantissa product.
    always_comb begin
        ea_s       = a[30:23];
        eb_s       = b[30:23];
        any_zero_s = (ea_s == 8'd0) || (eb_s == 8'd0);
        any_inf_s  = ((ea_s == 8'hFF) && (a[22:0] == 23'd0)) ||
                     ((eb_s == 8'hFF) && (b[22:0] == 23'd0));
        any_nan_s  = ((ea_s == 8'hFF) && (a[22:0] != 23'd0)) ||
                     ((eb_s == 8'hFF) && (b[22:0] != 23'd0));
        esum_s     = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 10'sd127;
        prod_s     = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_nan_r  <= 1'b0;
            s1_inf_r  <= 1'b0;
            s1_zero_r <= 1'b0;
            s1_esum_r <= 10'sd0;
            s1_prod_r <= '0;
            s1_tag_r  <= '0;
        end else if (adv1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= a[31] ^ b[31];
                s1_nan_r  <= any_nan_s || (any_inf_s && any_zero_s);
                s1_inf_r  <= any_inf_s;
                s1_zero_r <= any_zero_s;
                s1_esum_r <= esum_s;
                s1_prod_r <= prod_s[47:PLSB];
                s1_tag_r  <= in_tag;
            end
        end
    end

    // Normalize: the product of two [1,2) mantissas lies in [1,4), so at most one right shift.
    always_comb begin
        if (s1_prod_r[47]) begin
            mant_s   = s1_prod_r[46:24];
            esum_n_s = s1_esum_r + 10'sd1;
`ifdef FMUL_ROUND_NEAREST_EN
            guard_s  = s1_prod_r[23];
            sticky_s = |s1_prod_r[22:0];
`endif
        end else begin
            mant_s   = s1_prod_r[45:23];
            esum_n_s = s1_esum_r;
`ifdef FMUL_ROUND_NEAREST_EN
            guard_s  = s1_prod_r[22];
            sticky_s = |s1_prod_r[21:0];
`endif
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_r        <= 1'b0;
            s2_sign_r   <= 1'b0;
            s2_nan_r    <= 1'b0;
            s2_inf_r    <= 1'b0;
            s2_zero_r   <= 1'b0;
            s2_esum_r   <= 10'sd0;
            s2_mant_r   <= 23'd0;
            s2_tag_r    <= '0;
`ifdef FMUL_ROUND_NEAREST_EN
            s2_guard_r  <= 1'b0;
            s2_sticky_r <= 1'b0;
`endif
        end else if (adv2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                s2_sign_r   <= s1_sign_r;
                s2_nan_r    <= s1_nan_r;
                s2_inf_r    <= s1_inf_r;
                s2_zero_r   <= s1_zero_r;
                s2_esum_r   <= esum_n_s;
                s2_mant_r   <= mant_s;
                s2_tag_r    <= s1_tag_r;
`ifdef FMUL_ROUND_NEAREST_EN
                s2_guard_r  <= guard_s;
                s2_sticky_r <= sticky_s;
`endif
            end
        end
    end

    // Round (optional) and pack; specials take priority over range checks.
    always_comb begin
        mant_f_s = s2_mant_r;
        esum_f_s = s2_esum_r;
`ifdef FMUL_ROUND_NEAREST_EN
        if (s2_guard_r && (s2_sticky_r || s2_mant_r[0])) begin
            if (s2_mant_r == 23'h7FFFFF) begin
                mant_f_s = 23'd0;
                esum_f_s = s2_esum_r + 10'sd1;
            end else begin
                mant_f_s = s2_mant_r + 23'd1;
            end
        end else begin
            mant_f_s = s2_mant_r;
        end
`endif
        if (s2_nan_r) begin
            pack_s = 32'h7FC00000;
        end else if (s2_inf_r) begin
            pack_s = {s2_sign_r, 8'hFF, 23'd0};
        end else if (s2_zero_r) begin
            pack_s = {s2_sign_r, 31'd0};
        end else if (esum_f_s >= 10'sd255) begin
            pack_s = {s2_sign_r, 8'hFF, 23'd0};
        end else if (esum_f_s <= 10'sd0) begin
            pack_s = {s2_sign_r, 31'd0};
        end else begin
            pack_s = {s2_sign_r, esum_f_s[7:0], mant_f_s};
        end
    end

    // Stage 3 / output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3_r    <= 1'b0;
            p       <= 32'd0;
            out_tag <= '0;
        end else if (adv3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                p       <= pack_s;
                out_tag <= s2_tag_r;
            end
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: vector table, scoreboard queue, latency/backpressure/reset sequences.
module tb_fmul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] p;
    logic [3:0]  out_tag;

    logic [31:0] drv_exp = 32'd0;
    logic [35:0] sb[$];
    logic [35:0] sb_front;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

`ifdef FMUL_ROUND_NEAREST_EN
    localparam logic [31:0] TIE_EXP = 32'h3FC00002;
`else
    localparam logic [31:0] TIE_EXP = 32'h3FC00001;
`endif

    fmul_pipe #(.TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back({in_tag, drv_exp});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got p=%h tag=%h, expected no output", p, out_tag);
                end else begin
                    sb_front = sb.pop_front();
                    check("p", p, sb_front[31:0]);
                    check("out_tag", {28'd0, out_tag}, {28'd0, sb_front[35:32]});
                end
            end
        end
    end

    task automatic send(input logic [31:0] va, input logic [31:0] vb,
                        input logic [3:0] vt, input logic [31:0] ve);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; a = va; b = vb; in_tag = vt; drv_exp = ve;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d products outstanding, expected 0", sb.size());
        end
    endtask

    // Single op into an empty, unstalled pipe: out_valid must rise exactly 3 cycles after accept.
    task automatic lat_check(input logic [31:0] va, input logic [31:0] vb,
                             input logic [3:0] vt, input logic [31:0] ve);
        send(va, vb, vt, ve);
        idle();
        @(negedge clk); check("lat_c1_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check("lat_c2_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk); check("lat_c3_out_valid", {31'd0, out_valid}, 32'd1);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h40000000, 32'h40400000, 4'd1,  32'h40C00000};
        vecs[1]  = '{32'h3FC00000, 32'hBFC00000, 4'd2,  32'hC0100000};
        vecs[2]  = '{32'h7F000000, 32'h7F000000, 4'd3,  32'h7F800000};
        vecs[3]  = '{32'h00800000, 32'h00800000, 4'd4,  32'h00000000};
        vecs[4]  = '{32'h7F800000, 32'h00000000, 4'd5,  32'h7FC00000};
        vecs[5]  = '{32'h80000000, 32'h3F800000, 4'd6,  32'h80000000};
        vecs[6]  = '{32'h3F800001, 32'h3FC00000, 4'd7,  TIE_EXP};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 4'd8,  32'h7FC00000};
        vecs[8]  = '{32'hFF800000, 32'h40000000, 4'd9,  32'hFF800000};
        vecs[9]  = '{32'h00000001, 32'h3F800000, 4'd10, 32'h00000000};
        vecs[10] = '{32'hC0000000, 32'hC0400000, 4'd11, 32'h40C00000};
        vecs[11] = '{32'h3F800000, 32'h40000000, 4'd12, 32'h40000000};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_p", p, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        lat_check(32'h40000000, 32'h40400000, 4'd5, 32'h40C00000);

        for (int i = 0; i < 12; i++) send(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);
        idle();
        drain();

        // Backpressure: six back-to-back ops against a stalled consumer.
        @(posedge clk); #1 out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(vecs[i].a, vecs[i].b, i[3:0], vecs[i].exp);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
                check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
                check("bp_p_held", p, vecs[0].exp);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three ops in flight; none of them may emerge.
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h40000000, 32'h40400000, 4'd13 + i[3:0], 32'h40C00000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_p", p, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        lat_check(32'h3F800000, 32'h40000000, 4'd9, 32'h40000000);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
